// File: rtl/dmem_bytelane_if.sv
// Request/response bus for dmem_bytelane.
// Request: req_valid/req_ready handshake with req_we, req_size, req_unsigned,
// req_addr (byte address) and req_wdata (LSB-justified store data).
// Response: rsp_valid/rsp_ready handshake with rsp_rdata and rsp_err.
// master = LSU side (drives requests, consumes responses); slave = memory.
interface dmem_bytelane_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 9
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [XLEN-1:0]   rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_bytelane.sv
// DEPTH x XLEN data memory with byte-lane stores, registered 1-cycle loads
// with sign/zero extension, and valid/ready request/response handshakes.
// Ports:
//   clk   - clock, rising edge
//   rstn  - asynchronous active-low reset (response register only; array not reset)
//   bus   - dmem_bytelane_if.slave (request and response channels)
// Optional feature macro: DMEM_MISALIGN_CHK_EN
//   defined   - misaligned access (or size=11 with XLEN=32) returns rsp_err=1,
//               rsp_rdata=0 and writes nothing
//   undefined - low address bits below the access size are ignored; rsp_err=0
module dmem_bytelane #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned DEPTH  = 128,
    parameter int unsigned ADDR_W = 9
) (
    input  logic            clk,
    input  logic            rstn,
    dmem_bytelane_if.slave  bus
);
    localparam int unsigned LANES = XLEN / 8;
    localparam int unsigned OFF_W = $clog2(LANES);
    localparam int unsigned IDX_W = ADDR_W - OFF_W;

    logic [XLEN-1:0]  mem [DEPTH];

    logic             rsp_valid_q;
    logic [XLEN-1:0]  rsp_rdata_q;
    logic             rsp_err_q;

    logic             accept_c;
    logic [1:0]       size_c;
    logic [3:0]       nbm1_c;
    logic [OFF_W-1:0] raw_off_c;
    logic [OFF_W-1:0] align_mask_c;
    logic [OFF_W-1:0] off_c;
    logic [IDX_W-1:0] idx_c;
    logic             err_c;
    logic [LANES-1:0] be_c;
    logic [XLEN-1:0]  wshift_c;
    logic [XLEN-1:0]  rshift_c;
    logic [XLEN-1:0]  ext_c;

    // Single output register: a slot frees up as soon as the held response drains.
    assign bus.req_ready = !rsp_valid_q || bus.rsp_ready;
    assign accept_c      = bus.req_valid && bus.req_ready;

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

    // Address decode, lane enables, store alignment and load extraction.
    always_comb begin
        size_c = bus.req_size;
        if (XLEN == 32 && bus.req_size == 2'b11) begin
            size_c = 2'b10;
        end

        case (size_c)
            2'd0:    nbm1_c = 4'd0;
            2'd1:    nbm1_c = 4'd1;
            2'd2:    nbm1_c = 4'd3;
            default: nbm1_c = 4'd7;
        endcase

        align_mask_c = OFF_W'(nbm1_c);
        raw_off_c    = bus.req_addr[OFF_W-1:0];
        idx_c        = bus.req_addr[ADDR_W-1:OFF_W];

`ifdef DMEM_MISALIGN_CHK_EN
        err_c = (|(raw_off_c & align_mask_c)) || (XLEN == 32 && bus.req_size == 2'b11);
        off_c = raw_off_c;
`else
        err_c = 1'b0;
        off_c = raw_off_c & ~align_mask_c;
`endif

        be_c = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            be_c[i] = (i >= 32'(off_c)) && (i <= 32'(off_c) + 32'(nbm1_c));
        end

        wshift_c = bus.req_wdata << {off_c, 3'b000};
        rshift_c = mem[idx_c] >> {off_c, 3'b000};

        case (size_c)
            2'd0:    ext_c = bus.req_unsigned ? XLEN'(rshift_c[7:0])
                                              : XLEN'($signed(rshift_c[7:0]));
            2'd1:    ext_c = bus.req_unsigned ? XLEN'(rshift_c[15:0])
                                              : XLEN'($signed(rshift_c[15:0]));
            2'd2:    ext_c = bus.req_unsigned ? XLEN'(rshift_c[31:0])
                                              : XLEN'($signed(rshift_c[31:0]));
            default: ext_c = rshift_c;
        endcase
    end

    // Byte-lane store; erroring requests write nothing.
    always_ff @(posedge clk) begin
        if (accept_c && bus.req_we && !err_c) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (be_c[i]) begin
                    mem[idx_c][i*8 +: 8] <= wshift_c[i*8 +: 8];
                end
            end
        end
    end

    // Response register: load on accept, drop on drain, hold under backpressure.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else if (accept_c) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= (bus.req_we || err_c) ? '0 : ext_c;
            rsp_err_q   <= err_c;
        end else if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_dmem_bytelane.sv
module tb_dmem_bytelane;
    localparam int unsigned XLEN   = 32;
    localparam int unsigned DEPTH  = 128;
    localparam int unsigned ADDR_W = 9;

`ifdef DMEM_MISALIGN_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [8:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rstn;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   last_pop_cyc = 0;
    int   prev_pop_cyc = 0;
    exp_t sbq[$];
    exp_t mon_e;
    vec_t tbl[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_bytelane_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus ();

    dmem_bytelane #(.XLEN(XLEN), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                                input logic [8:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        return v;
    endfunction

    // Scoreboard consumer: compare each response at the handshake.
    always @(negedge clk) begin
        if (rstn === 1'b1 && bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp: got rdata %h with no request pending", bus.rsp_rdata);
            end else begin
                mon_e = sbq.pop_front();
                check("rsp_rdata", bus.rsp_rdata, mon_e.rdata);
                check("rsp_err", 32'(bus.rsp_err), 32'(mon_e.err));
                prev_pop_cyc = last_pop_cyc;
                last_pop_cyc = cyc;
            end
        end
    end

    task automatic drive(input vec_t v);
        bus.req_we       = v.we;
        bus.req_size     = v.size;
        bus.req_unsigned = v.uns;
        bus.req_addr     = v.addr;
        bus.req_wdata    = v.wdata;
        bus.req_valid    = 1'b1;
    endtask

    // Present a request, wait (bounded) for acceptance, push its expectation.
    task automatic send(input vec_t v);
        int n = 0;
        exp_t e;
        drive(v);
        @(negedge clk);
        while (bus.req_ready !== 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (bus.req_ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: req_ready %b required 1", bus.req_ready);
        end else begin
            e.rdata = v.exp_rdata;
            e.err   = v.exp_err;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("drain_pending", 32'(sbq.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;
        bus.rsp_ready    = 1'b1;
        rstn             = 1'b0;

        tbl.push_back(mk(1, 2'b10, 0, 9'h010, 32'hDEADBEEF, 32'h0, 0));
        tbl.push_back(mk(0, 2'b10, 0, 9'h010, 32'h0, 32'hDEADBEEF, 0));
        tbl.push_back(mk(1, 2'b00, 0, 9'h012, 32'hFFFFFF55, 32'h0, 0));
        tbl.push_back(mk(0, 2'b10, 0, 9'h010, 32'h0, 32'hDE55BEEF, 0));
        tbl.push_back(mk(0, 2'b00, 0, 9'h013, 32'h0, 32'hFFFFFFDE, 0));
        tbl.push_back(mk(0, 2'b00, 1, 9'h013, 32'h0, 32'h000000DE, 0));
        tbl.push_back(mk(0, 2'b00, 0, 9'h010, 32'h0, 32'hFFFFFFEF, 0));
        tbl.push_back(mk(1, 2'b10, 0, 9'h020, 32'h12345678, 32'h0, 0));
        tbl.push_back(mk(1, 2'b01, 0, 9'h022, 32'hABCD8001, 32'h0, 0));
        tbl.push_back(mk(0, 2'b01, 0, 9'h022, 32'h0, 32'hFFFF8001, 0));
        tbl.push_back(mk(0, 2'b01, 1, 9'h022, 32'h0, 32'h00008001, 0));
        tbl.push_back(mk(0, 2'b10, 0, 9'h020, 32'h0, 32'h80015678, 0));
        tbl.push_back(mk(0, 2'b01, 0, 9'h023, 32'h0, CHK ? 32'h0 : 32'hFFFF8001, CHK));
        tbl.push_back(mk(1, 2'b10, 0, 9'h030, 32'h00000000, 32'h0, 0));
        tbl.push_back(mk(1, 2'b10, 0, 9'h031, 32'hAAAAAAAA, 32'h0, CHK));
        tbl.push_back(mk(0, 2'b10, 0, 9'h030, 32'h0, CHK ? 32'h0 : 32'hAAAAAAAA, 0));
        tbl.push_back(mk(1, 2'b10, 0, 9'h048, 32'h33333333, 32'h0, 0));
        tbl.push_back(mk(0, 2'b11, 0, 9'h048, 32'h0, CHK ? 32'h0 : 32'h33333333, CHK));

        // Reset state
        #12;
        check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
        check("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("reset_req_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven vectors, issued back-to-back
        foreach (tbl[i]) send(tbl[i]);
        idle();
        wait_drain();

        // Backpressure: response held, request stalled, then released
        bus.rsp_ready = 1'b0;
        send(mk(0, 2'b10, 0, 9'h010, 32'h0, 32'hDE55BEEF, 0));
        drive(mk(0, 2'b10, 0, 9'h020, 32'h0, 32'h80015678, 0));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_req_ready", 32'(bus.req_ready), 32'd0);
            check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            check("bp_rsp_rdata", bus.rsp_rdata, 32'hDE55BEEF);
            check("bp_rsp_err", 32'(bus.rsp_err), 32'd0);
        end
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        #1;
        check("bp_release_req_ready", 32'(bus.req_ready), 32'd1);
        send(mk(0, 2'b10, 0, 9'h020, 32'h0, 32'h80015678, 0));
        idle();
        wait_drain();

        // Throughput and read-after-write
        send(mk(1, 2'b10, 0, 9'h040, 32'h11111111, 32'h0, 0));
        send(mk(0, 2'b10, 0, 9'h040, 32'h0, 32'h11111111, 0));
        idle();
        wait_drain();
        check("b2b_consecutive_rsp", 32'(last_pop_cyc - prev_pop_cyc), 32'd1);

        // Reset asserted with a response pending drops it; array keeps contents
        bus.rsp_ready = 1'b0;
        send(mk(0, 2'b10, 0, 9'h010, 32'h0, 32'hDE55BEEF, 0));
        idle();
        @(negedge clk);
        check("pre_reset_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        check("midreset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("midreset_rsp_rdata", bus.rsp_rdata, 32'd0);
        sbq.delete();
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        send(mk(0, 2'b10, 0, 9'h010, 32'h0, 32'hDE55BEEF, 0));
        idle();
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dmem_bytelane.md
Name: dmem_bytelane

Overview:
- Parametrised successor of the single-cycle data memory: a DEPTH x XLEN word array with byte-lane writes derived from access size and address.
- Registered (1-cycle) read with sign/zero extension done inside the block.
- Valid/ready request and response handshake with backpressure, so the LSU pipeline stage can stall cleanly.
- Sits between the core's memory stage and writeback; replaces the combinational-read dmem.

Parameters:
- XLEN, 32, data width in bits; legal values 32 or 64.
- DEPTH, 128, number of XLEN-bit words; power of two.
- ADDR_W, 9, byte-address bits used; must equal log2(DEPTH)+log2(XLEN/8).

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1=store, 0=load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 dword (dword legal only if XLEN=64).
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  XLEN  store data, LSB-justified.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  XLEN  extended load data; 0 for stores.
- rsp_err  out  1  access error (see Optional Feature).

Behaviour:
- Reset (rstn low, asynchronous): rsp_valid=0, rsp_rdata=0, rsp_err=0. The memory array is not reset.
- req_ready = !rsp_valid | rsp_ready (single output register). Combinational; no path from req_valid.
- Accept happens when req_valid & req_ready at a rising edge.
- Word index = req_addr[ADDR_W-1:log2(XLEN/8)]. Lane offset = low log2(XLEN/8) bits.
- Byte enables: size 2^s bytes starting at the lane offset.
- Store on accept:
  - Only enabled byte lanes are written, at that edge, from req_wdata low bytes shifted to the lane.
  - Next cycle: rsp_valid=1, rsp_rdata=0.
- Load on accept:
  - The word is read and selected lanes are shifted down.
  - Sign- or zero-extension is applied to XLEN.
  - Result is registered; rsp_valid=1 the next cycle (latency 1).
- Response hold: rsp_valid, rsp_rdata and rsp_err hold stable while rsp_valid & !rsp_ready.
- Response drain: if rsp_ready=1 and no new accept, rsp_valid drops to 0 next cycle.
- Back-to-back: with rsp_ready held 1, one request per cycle, full throughput.
- Read-after-write: a load accepted the cycle after a store to the same word returns the updated bytes. There is no bypass; only one request is accepted per cycle.
- size=11 with XLEN=32: treated as word (10).
- Reset asserted mid-transaction: any pending response is dropped. A store accepted at the same edge reset asserts is not guaranteed to be written.

Optional Feature:
- Macro: DMEM_MISALIGN_CHK_EN.
- Defined:
  - A request whose address is not naturally aligned to its size is an error; so is size=11 with XLEN=32.
  - On error: no byte is written; the response is returned with rsp_err=1 and rsp_rdata=0; latency and handshake are unchanged.
- Undefined:
  - Low address bits below the access size are forced to 0 (naturally aligned access at the truncated address).
  - rsp_err is tied to 0.

Test Plan:
- Reset then word store: sw 0xDEADBEEF to addr 0x010, then lw 0x010 → rsp_rdata=0xDEADBEEF one cycle after accept, rsp_err=0.
- Byte lanes: from word 0xDEADBEEF, sb 0x55 at 0x012, then lw 0x010 → 0xDE55BEEF. Then lb 0x013 → 0xFFFFFFDE; lbu 0x013 → 0x000000DE.
- Halfword: sh 0x8001 at 0x022, then lh 0x022 → 0xFFFF8001; lhu 0x022 → 0x00008001; lw 0x020 → upper half 0x8001, lower half unchanged.
- Backpressure: issue lw with rsp_ready=0 for 3 cycles → req_ready=0, rsp_valid and rsp_rdata stable for those cycles. Raise rsp_ready → response consumed and next request accepted in the same cycle.
- Throughput and read-after-write: back-to-back sw 0x11111111 @0x040, lw @0x040 with rsp_ready=1 → two consecutive rsp_valid cycles, second rsp_rdata=0x11111111.
- Misalign: sw 0xAAAAAAAA @0x031.
  - With DMEM_MISALIGN_CHK_EN: rsp_err=1 and word 0x030 unchanged.
  - Without it: word 0x030 = 0xAAAAAAAA, rsp_err=0.
